// File: rtl/microwave_controller.sv
// Microwave oven sequencer: keypad entry, cook/pause/done control of an external
// BCD countdown timer, magnetron enable and done beeper. All outputs are registered.
module microwave_controller #(
  parameter int unsigned CLK_DIV    = 100,
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       cancel_btn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       timer_zero,
  output logic       timer_load,
  output logic [3:0] timer_digit,
  output logic       timer_clear,
  output logic       timer_stop,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEntry = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [15:0] PrescMax = 16'(CLK_DIV - 1);
  localparam logic [3:0]  BeepMax  = 4'(BEEP_TICKS - 1);

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic [3:0]  beep_cnt_q, beep_cnt_d;

  logic        start_prev_q, stop_prev_q, cancel_prev_q, key_prev_q, door_prev_q;

  logic        load_q, load_d;
  logic [3:0]  digit_q, digit_d;
  logic        clear_q, clear_d;
  logic        tstop_q, tstop_d;
  logic        mag_q, mag_d;
  logic        beep_q, beep_d;

  logic        start_rise, stop_rise, cancel_rise, key_rise, door_fall;

  assign start_rise  = start_btn & ~start_prev_q;
  assign stop_rise   = stop_btn & ~stop_prev_q;
  assign cancel_rise = cancel_btn & ~cancel_prev_q;
  assign key_rise    = key_valid & ~key_prev_q;
  assign door_fall   = ~door_closed & door_prev_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= StIdle;
      count_q       <= 2'd0;
      presc_q       <= 16'd0;
      beep_cnt_q    <= 4'd0;
      start_prev_q  <= 1'b0;
      stop_prev_q   <= 1'b0;
      cancel_prev_q <= 1'b0;
      key_prev_q    <= 1'b0;
      door_prev_q   <= 1'b0;
      load_q        <= 1'b0;
      digit_q       <= 4'd0;
      clear_q       <= 1'b0;
      tstop_q       <= 1'b1;
      mag_q         <= 1'b0;
      beep_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      presc_q       <= presc_d;
      beep_cnt_q    <= beep_cnt_d;
      start_prev_q  <= start_btn;
      stop_prev_q   <= stop_btn;
      cancel_prev_q <= cancel_btn;
      key_prev_q    <= key_valid;
      door_prev_q   <= door_closed;
      load_q        <= load_d;
      digit_q       <= digit_d;
      clear_q       <= clear_d;
      tstop_q       <= tstop_d;
      mag_q         <= mag_d;
      beep_q        <= beep_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    beep_cnt_d = beep_cnt_q;
    load_d     = 1'b0;
    digit_d    = 4'd0;
    clear_d    = 1'b0;
    tstop_d    = 1'b1;

    case (state_q)
      StIdle, StEntry: begin
        if (cancel_rise) begin
          clear_d = 1'b1;
          count_d = 2'd0;
          state_d = StIdle;
        end else if (!(door_fall || stop_rise)) begin
          // A start edge takes priority over a key edge even when it is refused.
          if (start_rise) begin
            if (door_closed && !timer_zero) begin
              state_d = StCook;
              presc_d = 16'd0;
            end
          end else if (key_rise && (key_digit <= 4'd9) && (count_q < 2'd3)) begin
            load_d  = 1'b1;
            digit_d = key_digit;
            count_d = count_q + 2'd1;
            state_d = StEntry;
          end
        end
      end

      StCook: begin
        if (cancel_rise) begin
          clear_d = 1'b1;
          count_d = 2'd0;
          state_d = StIdle;
        end else if (door_fall || stop_rise) begin
          state_d = StPause;
        end else if (timer_zero) begin
          state_d    = StDone;
          presc_d    = 16'd0;
          beep_cnt_d = 4'd0;
        end else if (presc_q == PrescMax) begin
          presc_d = 16'd0;
          tstop_d = 1'b0;
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end

      StPause: begin
        if (cancel_rise) begin
          clear_d = 1'b1;
          count_d = 2'd0;
          state_d = StIdle;
        end else if (start_rise && door_closed) begin
          state_d = StCook;
        end
      end

      StDone: begin
        if (cancel_rise || door_fall) begin
          count_d = 2'd0;
          state_d = StIdle;
        end else if (presc_q == PrescMax) begin
          presc_d = 16'd0;
          if (beep_cnt_q == BeepMax) begin
            beep_cnt_d = 4'd0;
            count_d    = 2'd0;
            state_d    = StIdle;
          end else begin
            beep_cnt_d = beep_cnt_q + 4'd1;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end

      default: state_d = StIdle;
    endcase

    mag_d  = (state_d == StCook);
    beep_d = (state_d == StDone);
  end

  assign timer_load  = load_q;
  assign timer_digit = digit_q;
  assign timer_clear = clear_q;
  assign timer_stop  = tstop_q;
  assign mag_on      = mag_q;
  assign beep        = beep_q;
  assign state       = state_q;

endmodule

// File: tb/tb_microwave_controller.sv
// Bench for microwave_controller (CLK_DIV=4, BEEP_TICKS=2): vector table with a
// scoreboard queue of expected outputs, plus an asynchronous reset mid-cook.
module tb_microwave_controller;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       start_btn, stop_btn, cancel_btn, door_closed, key_valid, timer_zero;
  logic [3:0] key_digit;
  logic       timer_load, timer_clear, timer_stop, mag_on, beep;
  logic [3:0] timer_digit;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  microwave_controller #(.CLK_DIV(4), .BEEP_TICKS(2)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .start_btn  (start_btn),
    .stop_btn   (stop_btn),
    .cancel_btn (cancel_btn),
    .door_closed(door_closed),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .timer_zero (timer_zero),
    .timer_load (timer_load),
    .timer_digit(timer_digit),
    .timer_clear(timer_clear),
    .timer_stop (timer_stop),
    .mag_on     (mag_on),
    .beep       (beep),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Output bundle: load, digit[3:0], clear, tstop, mag, beep, state[2:0]
  typedef struct packed {
    logic st, sp, ca, dr, kv;
    logic [3:0] kd;
    logic tz;
    logic [11:0] exp_out;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] sb_q[$];

  function automatic vec_t v(input logic st, sp, ca, dr, kv, input logic [3:0] kd,
                             input logic tz, ld, input logic [3:0] dg,
                             input logic cl, ts, mg, bp, input logic [2:0] s);
    vec_t r;
    r.st = st; r.sp = sp; r.ca = ca; r.dr = dr; r.kv = kv; r.kd = kd; r.tz = tz;
    r.exp_out = {ld, dg, cl, ts, mg, bp, s};
    return r;
  endfunction

  function automatic logic [11:0] outs();
    return {timer_load, timer_digit, timer_clear, timer_stop, mag_on, beep, state};
  endfunction

  task automatic compare(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ld=%b dg=%0d cl=%b ts=%b mg=%b bp=%b st=%0d, expected ld=%b dg=%0d cl=%b ts=%b mg=%b bp=%b st=%0d",
               name, got[11], got[10:7], got[6], got[5], got[4], got[3], got[2:0],
               exp[11], exp[10:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic run_vec(input int idx);
    logic [11:0] e;
    @(negedge clk);
    start_btn   = vecs[idx].st;
    stop_btn    = vecs[idx].sp;
    cancel_btn  = vecs[idx].ca;
    door_closed = vecs[idx].dr;
    key_valid   = vecs[idx].kv;
    key_digit   = vecs[idx].kd;
    timer_zero  = vecs[idx].tz;
    sb_q.push_back(vecs[idx].exp_out);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare($sformatf("vec%0d", idx), outs(), e);
  endtask

  localparam logic [11:0] ResetOut = {1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

  int split;

  initial begin
    //       st sp ca dr kv kd  tz   ld dg cl ts mg bp st
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 0,  1, 1, 0, 1, 0, 0, 1)); // key 1
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 3, 0,  1, 3, 0, 1, 0, 0, 1)); // key 3
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0, 1)); // key 0
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 0, 0, 1)); // held, no edge
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 5, 0,  0, 0, 0, 1, 0, 0, 1)); // 4th key ignored
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2)); // start -> cook
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 2)); // tick
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 2)); // tick
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2)); // prescaler now 2
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3)); // door open -> pause
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2)); // resume
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 2)); // tick 2 cycles on
    vecs.push_back(v(0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3)); // stop -> pause
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3));
    vecs.push_back(v(0, 0, 0, 1, 1, 7, 0,  0, 0, 0, 1, 0, 0, 3)); // key in pause ignored
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 3));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 1, 4)); // zero -> done
    for (int i = 0; i < 7; i++)
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 4));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0)); // beep over
    vecs.push_back(v(0, 0, 0, 1, 1, 4, 0,  1, 4, 0, 1, 0, 0, 1)); // count restarted
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(1, 0, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0)); // start+cancel
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 12, 0, 0, 0, 0, 1, 0, 0, 0)); // digit > 9
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    split = vecs.size();
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2)); // after reset
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 1, 4));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0)); // door open in done
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 2));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0)); // cancel in cook
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));

    clear_n = 1'b0;
    start_btn = 0; stop_btn = 0; cancel_btn = 0; door_closed = 1;
    key_valid = 0; key_digit = 0; timer_zero = 0;
    repeat (2) @(negedge clk);
    compare("reset", outs(), ResetOut);
    clear_n = 1'b1;

    for (int i = 0; i < split; i++) run_vec(i);

    // Asynchronous reset between clock edges while cooking.
    @(negedge clk);
    #1 clear_n = 1'b0;
    #2;
    compare("async_reset_mid_cook", outs(), ResetOut);
    @(negedge clk);
    compare("reset_held", outs(), ResetOut);
    clear_n = 1'b1;

    for (int i = split; i < vecs.size(); i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microwave_controller.md
MICROWAVE_CONTROLLER -- requirements
Module: microwave_controller

Interface
REQ-001 Parameter CLK_DIV, default 100, clk cycles per one-second tick; legal range 2..65535.
REQ-002 Parameter BEEP_TICKS, default 3, ticks the done indication lasts; legal range 1..15.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 clear_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start_btn  input  1  start/resume request, level, clk-synchronous.
REQ-006 stop_btn  input  1  pause request, level, clk-synchronous.
REQ-007 cancel_btn  input  1  cancel/clear request, level, clk-synchronous.
REQ-008 door_closed  input  1  1 = door closed.
REQ-009 key_valid  input  1  keypad digit present, level, clk-synchronous.
REQ-010 key_digit  input  4  keypad BCD digit; values above 9 are ignored.
REQ-011 timer_zero  input  1  1 = timer reads 0:00.
REQ-012 timer_load  output  1  one-cycle pulse; shifts timer_digit into the timer digit chain.
REQ-013 timer_digit  output  4  BCD digit presented with timer_load.
REQ-014 timer_clear  output  1  one-cycle pulse; zeroes the timer.
REQ-015 timer_stop  output  1  1 = timer holds; 0 for exactly one cycle per tick lets it decrement once.
REQ-016 mag_on  output  1  magnetron enable.
REQ-017 beep  output  1  done indication.
REQ-018 state  output  3  current state encoding, for display/debug.

Function
REQ-019 Each button, key_valid, and door_closed falling edge SHALL be detected against a registered previous value; only rising edges (falling for door) cause actions.
REQ-020 All outputs SHALL be registered; the response to an edge appears on the cycle after the input changes.
REQ-021 States SHALL be IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4; codes 5..7 SHALL return to IDLE next cycle.
REQ-022 Event priority in one cycle SHALL be cancel > door open > stop > start > key.
REQ-023 IDLE/ENTRY, valid key edge with key_digit<=9 and digit count<3: one timer_load pulse with timer_digit=key_digit, count++, state ENTRY.
REQ-024 Key edges with count=3, or key_digit>9, SHALL be ignored without any output pulse.
REQ-025 IDLE/ENTRY, start edge with door_closed=1 and timer_zero=0: state COOK, prescaler reset to 0; otherwise the start edge is ignored.
REQ-026 IDLE/ENTRY, cancel edge: timer_clear pulse, count=0, state IDLE.
REQ-027 COOK: mag_on=1; prescaler counts 0..CLK_DIV-1 and wraps; on the wrap cycle timer_stop=0 for one cycle, else timer_stop=1.
REQ-028 COOK, timer_zero=1 sampled: state DONE next cycle, mag_on=0, no further tick emitted.
REQ-029 COOK, stop edge or door open: state PAUSE, mag_on=0, prescaler frozen at its current value.
REQ-030 PAUSE, start edge with door_closed=1: state COOK, prescaler resumes from its frozen value.
REQ-031 PAUSE or COOK, cancel edge: timer_clear pulse, count=0, mag_on=0, state IDLE.
REQ-032 PAUSE: key edges ignored.
REQ-033 DONE: beep=1; prescaler runs; after BEEP_TICKS wraps: beep=0, count=0, state IDLE.
REQ-034 DONE, cancel edge or door open: beep=0, count=0, state IDLE immediately; start ignored.
REQ-035 timer_stop SHALL be 1 in every state other than the COOK tick cycle.
REQ-036 mag_on SHALL never be 1 while door_closed=0 for more than one cycle.

Reset
REQ-037 While clear_n=0: state=IDLE, count=0, prescaler=0, beep counter=0, timer_load=0, timer_digit=0, timer_clear=0, timer_stop=1, mag_on=0, beep=0.
REQ-038 Reset mid-COOK SHALL drop mag_on asynchronously and issue no timer_clear pulse.

Verification (CLK_DIV=4, BEEP_TICKS=2)
REQ-039 Keys 1,3,0 -> three timer_load pulses with digits 1,3,0; state=1; fourth key 5 -> no pulse.
REQ-040 Start with door closed and timer_zero=0 -> state=2, mag_on=1; timer_stop low once every 4 cycles.
REQ-041 Door opens in COOK at prescaler=2 -> state=3, mag_on=0; close door then start -> next tick 2 cycles later.
REQ-042 timer_zero=1 in COOK -> state=4, beep=1 for 8 cycles, then state=0.
REQ-043 Start and cancel asserted the same cycle in ENTRY -> timer_clear pulse, state=0, mag_on stays 0.
REQ-044 clear_n low mid-COOK -> mag_on=0 with no clock edge; all outputs at REQ-037 values.
